// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 32-step shift-add multiplier and restoring divider
// sharing one iterative datapath, with single-cycle special cases for division.
module muldiv_unit (
   input  logic        clk_in,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic [4:0]  rd_in,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rd_out
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e      state_q;
   logic [2:0]  op_q;
   logic        neg_q;
   logic [31:0] hi_q, lo_q, b_q;
   logic [4:0]  cnt_q;
   logic [4:0]  rd_q;

   logic        a_signed, b_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic        div_zero, div_ovf, fast;
   logic [31:0] fast_res;
   logic [32:0] mul_sum, div_shift, div_diff;
   logic [31:0] hi_n, lo_n;
   logic [63:0] prod, prod_s;
   logic [31:0] quo_s, rem_s, final_res;

   assign busy = (state_q == StCalc);
   assign done = (state_q == StDone);

   always_comb begin
      a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
      b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
      a_neg    = a_signed & operand_a[31];
      b_neg    = b_signed & operand_b[31];
      a_mag    = a_neg ? -operand_a : operand_a;
      b_mag    = b_neg ? -operand_b : operand_b;
      div_zero = funct3[2] && (operand_b == 32'd0);
      div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                 (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
      fast     = div_zero || div_ovf;
      // funct3[1] selects remainder among the divide ops
      if (div_zero) fast_res = funct3[1] ? operand_a : 32'hFFFF_FFFF;
      else          fast_res = funct3[1] ? 32'd0 : 32'h8000_0000;
   end

   // One iteration of either core; hi holds partial product / remainder, lo the
   // multiplier / dividend bits being consumed.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
      div_shift = {hi_q, lo_q[31]};
      div_diff  = div_shift - {1'b0, b_q};
      if (op_q[2]) begin
         if (!div_diff[32]) begin
            hi_n = div_diff[31:0];
            lo_n = {lo_q[30:0], 1'b1};
         end else begin
            hi_n = div_shift[31:0];
            lo_n = {lo_q[30:0], 1'b0};
         end
      end else begin
         hi_n = mul_sum[32:1];
         lo_n = {mul_sum[0], lo_q[31:1]};
      end
      prod   = {hi_n, lo_n};
      prod_s = neg_q ? -prod : prod;
      quo_s  = neg_q ? -lo_n : lo_n;
      rem_s  = neg_q ? -hi_n : hi_n;
      if (op_q[2])                final_res = op_q[1] ? rem_s : quo_s;
      else if (op_q == 3'b000)    final_res = prod_s[31:0];
      else                        final_res = prod_s[63:32];
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         op_q    <= 3'd0;
         neg_q   <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         b_q     <= 32'd0;
         cnt_q   <= 5'd0;
         rd_q    <= 5'd0;
         result  <= 32'd0;
         rd_out  <= 5'd0;
      end else if (flush) begin
         state_q <= StIdle;
      end else if (state_q == StCalc) begin
         hi_q  <= hi_n;
         lo_q  <= lo_n;
         cnt_q <= cnt_q + 5'd1;
         if (cnt_q == 5'd31) begin
            state_q <= StDone;
            result  <= final_res;
            rd_out  <= rd_q;
         end
      end else if (start) begin
         if (fast) begin
            state_q <= StDone;
            result  <= fast_res;
            rd_out  <= rd_in;
         end else begin
            state_q <= StCalc;
            op_q    <= funct3;
            neg_q   <= (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
            hi_q    <= 32'd0;
            lo_q    <= a_mag;
            b_q     <= b_mag;
            cnt_q   <= 5'd0;
            rd_q    <= rd_in;
         end
      end else begin
         state_q <= StIdle;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

   logic        clk_in = 1'b0;
   logic        reset_n;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] operand_a, operand_b;
   logic [4:0]  rd_in;
   logic        flush;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_unit dut (
      .clk_in    (clk_in),
      .reset_n   (reset_n),
      .start     (start),
      .funct3    (funct3),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .rd_in     (rd_in),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .rd_out    (rd_out)
   );

   always #5 clk_in = ~clk_in;

   // Launch one op, scramble inputs after acceptance, wait (bounded) for done.
   // lat = edges after the accepting edge at which done is seen (999 = timeout).
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output int busy_cnt,
                         output logic [31:0] res, output logic [4:0] rdo);
      @(negedge clk_in);
      start = 1'b1; funct3 = f; operand_a = a; operand_b = b; rd_in = rd;
      @(posedge clk_in); #1;
      start = 1'b0; funct3 = ~f; operand_a = ~a; operand_b = ~b; rd_in = ~rd;
      lat = 0; busy_cnt = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) busy_cnt++;
         @(posedge clk_in); #1;
         lat++;
      end
      if (lat >= 100) lat = 999;
      res = result; rdo = rd_out;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0;
      operand_a = 32'd0; operand_b = 32'd0; rd_in = 5'd0;
      repeat (3) @(posedge clk_in);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
      n_checks++; if (rd_out !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", rd_out); end
      #1 reset_n = 1'b1;
   endtask

   task automatic test_mul;
      int lat, bc; logic [31:0] r; logic [4:0] rd;
      run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, lat, bc, r, rd);
      n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL mul_latency got %0d want 32", lat); end
      n_checks++; if (bc !== 32) begin n_fail++; $display("FAIL mul_busy_cycles got %0d want 32", bc); end
      n_checks++; if (r !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result got %h want ffffffeb", r); end
      n_checks++; if (rd !== 5'd5) begin n_fail++; $display("FAIL mul_rd got %0d want 5", rd); end
   endtask

   task automatic test_mulh;
      int lat, bc; logic [31:0] r; logic [4:0] rd;
      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, lat, bc, r, rd);
      n_checks++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh got %h want 40000000", r); end
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, lat, bc, r, rd);
      n_checks++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu got %h want fffffffe", r); end
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, lat, bc, r, rd);
      n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu got %h want ffffffff", r); end
      n_checks++; if (rd !== 5'd3) begin n_fail++; $display("FAIL mulhsu_rd got %0d want 3", rd); end
   endtask

   task automatic test_div;
      int lat, bc; logic [31:0] r; logic [4:0] rd;
      run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, lat, bc, r, rd);
      n_checks++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div got %h want fffffffd", r); end
      n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL div_latency got %0d want 32", lat); end
      run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, lat, bc, r, rd);
      n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem got %h want ffffffff", r); end
      run_op(3'b101, 32'd100, 32'd7, 5'd12, lat, bc, r, rd);
      n_checks++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu got %0d want 14", r); end
      run_op(3'b111, 32'd100, 32'd7, 5'd13, lat, bc, r, rd);
      n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu got %0d want 2", r); end
      n_checks++; if (rd !== 5'd13) begin n_fail++; $display("FAIL remu_rd got %0d want 13", rd); end
   endtask

   task automatic test_fast_path;
      int lat, bc; logic [31:0] r; logic [4:0] rd;
      run_op(3'b101, 32'd5, 32'd0, 5'd20, lat, bc, r, rd);
      n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0 got %h want ffffffff", r); end
      n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL divu0_latency got %0d want 0", lat); end
      n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL divu0_busy got %0d want 0", bc); end
      n_checks++; if (rd !== 5'd20) begin n_fail++; $display("FAIL divu0_rd got %0d want 20", rd); end
      run_op(3'b111, 32'd5, 32'd0, 5'd21, lat, bc, r, rd);
      n_checks++; if (r !== 32'd5) begin n_fail++; $display("FAIL remu0 got %h want 5", r); end
      n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL remu0_latency got %0d want 0", lat); end
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, lat, bc, r, rd);
      n_checks++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf got %h want 80000000", r); end
      n_checks++; if (lat !== 0 || bc !== 0) begin n_fail++; $display("FAIL div_ovf_timing got lat %0d busy %0d want 0 0", lat, bc); end
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, lat, bc, r, rd);
      n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL rem_ovf got %h want 0", r); end
      n_checks++; if (lat !== 0 || bc !== 0) begin n_fail++; $display("FAIL rem_ovf_timing got lat %0d busy %0d want 0 0", lat, bc); end
   endtask

   task automatic test_flush;
      int lat, bc; logic [31:0] r; logic [4:0] rd; int seen;
      run_op(3'b101, 32'd100, 32'd7, 5'd2, lat, bc, r, rd);
      @(negedge clk_in);
      start = 1'b1; funct3 = 3'b000; operand_a = 32'd7; operand_b = 32'd9; rd_in = 5'd4;
      @(posedge clk_in); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk_in); #1; end
      flush = 1'b1;
      @(posedge clk_in); #1;
      flush = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
      seen = 0;
      repeat (40) begin
         if (done === 1'b1) seen++;
         @(posedge clk_in); #1;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done got %0d pulses want 0", seen); end
      n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result got %0d want 14", result); end
      n_checks++; if (rd_out !== 5'd2) begin n_fail++; $display("FAIL flush_rd got %0d want 2", rd_out); end
      // start together with flush must be dropped
      @(negedge clk_in);
      start = 1'b1; flush = 1'b1; funct3 = 3'b000; operand_a = 32'd3; operand_b = 32'd3;
      @(posedge clk_in); #1;
      start = 1'b0; flush = 1'b0;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL start_flush got busy %b done %b want 0 0", busy, done); end
   endtask

   task automatic test_back_to_back;
      int lat, bc; logic [31:0] r; logic [4:0] rd;
      run_op(3'b101, 32'd100, 32'd7, 5'd8, lat, bc, r, rd);
      n_checks++; if (r !== 32'd14) begin n_fail++; $display("FAIL b2b_first got %0d want 14", r); end
      // still inside the DONE cycle: issue the next op
      start = 1'b1; funct3 = 3'b111; operand_a = 32'd100; operand_b = 32'd7; rd_in = 5'd9;
      @(posedge clk_in); #1;
      start = 1'b0; operand_a = 32'd0;
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin @(posedge clk_in); #1; lat++; end
      n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL b2b_latency got %0d want 32", lat); end
      n_checks++; if (result !== 32'd2) begin n_fail++; $display("FAIL b2b_result got %0d want 2", result); end
      n_checks++; if (rd_out !== 5'd9) begin n_fail++; $display("FAIL b2b_rd got %0d want 9", rd_out); end
   endtask

   task automatic test_start_in_calc;
      int lat;
      @(negedge clk_in);
      start = 1'b1; funct3 = 3'b000; operand_a = 32'd3; operand_b = 32'd4; rd_in = 5'd3;
      @(posedge clk_in); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk_in); #1; end
      start = 1'b1; funct3 = 3'b011; operand_a = 32'hFFFF_FFFF; operand_b = 32'd2; rd_in = 5'd7;
      @(posedge clk_in); #1;
      start = 1'b0;
      lat = 5;
      while (done !== 1'b1 && lat < 100) begin @(posedge clk_in); #1; lat++; end
      n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL calc_start_latency got %0d want 32", lat); end
      n_checks++; if (result !== 32'd12) begin n_fail++; $display("FAIL calc_start_result got %0d want 12", result); end
      n_checks++; if (rd_out !== 5'd3) begin n_fail++; $display("FAIL calc_start_rd got %0d want 3", rd_out); end
      @(posedge clk_in); #1;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL calc_start_idle got busy %b done %b want 0 0", busy, done); end
   endtask

   task automatic test_reset_mid_calc;
      int seen;
      @(negedge clk_in);
      start = 1'b1; funct3 = 3'b000; operand_a = 32'd5; operand_b = 32'd5; rd_in = 5'd6;
      @(posedge clk_in); #1;
      start = 1'b0;
      repeat (10) begin @(posedge clk_in); #1; end
      reset_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", done); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL rstmid_result got %h want 0", result); end
      n_checks++; if (rd_out !== 5'd0) begin n_fail++; $display("FAIL rstmid_rd got %0d want 0", rd_out); end
      @(negedge clk_in);
      reset_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk_in); #1;
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d active cycles want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_fast_path();
      test_flush();
      test_back_to_back();
      test_start_in_calc();
      test_reset_mid_calc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
